// File: rtl/pcie_msg_transmitter.sv
// Message transmitter: reads a payload from SRAM and sends it as SG or S/M/L AXI write bursts.
// Optional macro PCIE_MSG_TX_BRESP_RETRY_EN: re-send a fragment once on a non-OKAY B response.
module pcie_msg_transmitter #(
  parameter int unsigned MAX_PAYLOAD_BEATS = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_start,
  input  logic [119:0] msg_tlp,
  input  logic [3:0]   msg_tag,
  input  logic [11:0]  msg_length,
  input  logic [9:0]   msg_sram_addr,
  input  logic [63:0]  msg_axi_addr,
  output logic         msg_busy,
  output logic         msg_done,
  output logic         msg_error,
  output logic         sram_ren,
  output logic [9:0]   sram_raddr,
  input  logic [255:0] sram_rdata,
  output logic         axi_awvalid,
  output logic [63:0]  axi_awaddr,
  output logic [11:0]  axi_awlen,
  output logic [2:0]   axi_awsize,
  output logic [1:0]   axi_awburst,
  input  logic         axi_awready,
  output logic         axi_wvalid,
  output logic [255:0] axi_wdata,
  output logic [31:0]  axi_wstrb,
  output logic         axi_wlast,
  input  logic         axi_wready,
  input  logic         axi_bvalid,
  input  logic [1:0]   axi_bresp,
  output logic         axi_bready
);

  localparam logic [11:0] MaxBeats = 12'(MAX_PAYLOAD_BEATS);

  typedef enum logic [2:0] {
    StIdle, StAw, StWHdr, StRd, StRdWait, StWData, StB, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [119:0]   tlp_q, tlp_d;
  logic [3:0]     tag_q, tag_d;
  logic [11:0]    rem_q, rem_d;
  logic [9:0]     cur_addr_q, cur_addr_d;
  logic [9:0]     frag_addr_q, frag_addr_d;
  logic [1:0]     sn_q, sn_d;
  logic           first_q, first_d;
  logic [1:0]     frag_type_q, frag_type_d;
  logic [3:0]     frag_beats_q, frag_beats_d;
  logic [3:0]     beat_cnt_q, beat_cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic           ren_q, ren_d;
  logic [9:0]     raddr_q, raddr_d;
  logic           awvalid_q, awvalid_d;
  logic [63:0]    awaddr_q, awaddr_d;
  logic [11:0]    awlen_q, awlen_d;
  logic           wvalid_q, wvalid_d;
  logic [255:0]   wdata_q, wdata_d;
  logic           wlast_q, wlast_d;
  logic           bready_q, bready_d;
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
  logic           retry_q, retry_d;
`endif

  logic        more;
  logic [11:0] frag_len;
  assign more     = rem_q > MaxBeats;
  assign frag_len = more ? MaxBeats : rem_q;

  always_comb begin
    state_d      = state_q;
    tlp_d        = tlp_q;
    tag_d        = tag_q;
    rem_d        = rem_q;
    cur_addr_d   = cur_addr_q;
    frag_addr_d  = frag_addr_q;
    sn_d         = sn_q;
    first_d      = first_q;
    frag_type_d  = frag_type_q;
    frag_beats_d = frag_beats_q;
    beat_cnt_d   = beat_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    ren_d        = 1'b0;
    raddr_d      = raddr_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    wlast_d      = wlast_q;
    bready_d     = bready_q;
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
    retry_d      = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (msg_start) begin
          if (msg_length == 12'd0 || msg_tag == 4'hF) begin
            error_d = 1'b1;
          end else begin
            tlp_d       = msg_tlp;
            tag_d       = msg_tag;
            rem_d       = msg_length;
            cur_addr_d  = msg_sram_addr;
            frag_addr_d = msg_sram_addr;
            awaddr_d    = msg_axi_addr;
            sn_d        = 2'd0;
            first_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = StAw;
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
            retry_d     = 1'b0;
`endif
          end
        end
      end
      StAw: begin
        if (!awvalid_q) begin
          // Type encodes {first fragment, fits in one fragment}: S=10 SG=11 M=00 L=01.
          awvalid_d    = 1'b1;
          awlen_d      = frag_len;
          frag_beats_d = frag_len[3:0];
          frag_type_d  = {first_q, !more};
        end else if (axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = {128'b0, frag_type_q, sn_q, tag_q, tlp_q};
          wlast_d   = 1'b0;
          state_d   = StWHdr;
        end
      end
      StWHdr: begin
        if (axi_wready) begin
          wvalid_d   = 1'b0;
          ren_d      = 1'b1;
          raddr_d    = cur_addr_q;
          beat_cnt_d = 4'd0;
          state_d    = StRd;
        end
      end
      StRd: state_d = StRdWait;
      StRdWait: begin
        wvalid_d   = 1'b1;
        wdata_d    = sram_rdata;
        wlast_d    = (beat_cnt_q == frag_beats_q - 4'd1);
        cur_addr_d = cur_addr_q + 10'd1;
        state_d    = StWData;
      end
      StWData: begin
        if (axi_wready) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          if (wlast_q) begin
            bready_d = 1'b1;
            state_d  = StB;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            ren_d      = 1'b1;
            raddr_d    = cur_addr_q;
            state_d    = StRd;
          end
        end
      end
      StB: begin
        if (axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          if (axi_bresp == 2'b00) begin
            sn_d        = sn_q + 2'd1;
            first_d     = 1'b0;
            rem_d       = rem_q - {8'b0, frag_beats_q};
            frag_addr_d = cur_addr_q;
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
            retry_d     = 1'b0;
`endif
            if (frag_type_q[0]) begin
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StAw;
            end
          end else begin
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
            // Rewind to the fragment start; rem/SN/first are untouched so the header repeats.
            if (!retry_q) begin
              retry_d    = 1'b1;
              cur_addr_d = frag_addr_q;
              state_d    = StAw;
            end else begin
              error_d = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end
`else
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
`endif
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tlp_q        <= '0;
      tag_q        <= '0;
      rem_q        <= '0;
      cur_addr_q   <= '0;
      frag_addr_q  <= '0;
      sn_q         <= '0;
      first_q      <= 1'b0;
      frag_type_q  <= '0;
      frag_beats_q <= '0;
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
      retry_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tlp_q        <= tlp_d;
      tag_q        <= tag_d;
      rem_q        <= rem_d;
      cur_addr_q   <= cur_addr_d;
      frag_addr_q  <= frag_addr_d;
      sn_q         <= sn_d;
      first_q      <= first_d;
      frag_type_q  <= frag_type_d;
      frag_beats_q <= frag_beats_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      ren_q        <= ren_d;
      raddr_q      <= raddr_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
`ifdef PCIE_MSG_TX_BRESP_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign msg_busy    = busy_q;
  assign msg_done    = done_q;
  assign msg_error   = error_q;
  assign sram_ren    = ren_q;
  assign sram_raddr  = raddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = 3'b101;
  assign axi_awburst = 2'b01;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = '1;
  assign axi_wlast   = wlast_q;
  assign axi_bready  = bready_q;

endmodule

// File: doc/pcie_msg_transmitter.md
# pcie_msg_transmitter

Transmit-side counterpart of the message receiver. It reads a message payload from local SRAM and fragments it into S/M/L packets, or sends it as a single SG packet. Each fragment goes out as one AXI write burst whose first beat carries the 128-bit message header. It sits between the message-issue logic and the AXI fabric that feeds the remote message receiver.

## Interface
- `MAX_PAYLOAD_BEATS`, default 15: payload beats per fragment, range 1..15. A fragment is at most 16 beats including the header.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `msg_start` in 1: request pulse. Accepted only while `msg_busy`=0.
- `msg_tlp` in 120: TLP header field, placed in header bits [119:0].
- `msg_tag` in 4: MSG_TAG. Legal values are 0..14.
- `msg_length` in 12: payload length in beats. Legal values are 1..4095.
- `msg_sram_addr` in 10: SRAM address of payload beat 0.
- `msg_axi_addr` in 64: AWADDR used for every fragment of the message.
- `msg_busy` out 1: high from the accept edge until done or abort.
- `msg_done` out 1: one-cycle pulse after the last B response returns OKAY.
- `msg_error` out 1: one-cycle pulse on an illegal request or an abort.
- `sram_ren` out 1, `sram_raddr` out 10: SRAM read request.
- `sram_rdata` in 256: read data, valid one cycle after `sram_ren`.
- `axi_awvalid` out 1, `axi_awaddr` out 64, `axi_awlen` out 12, `axi_awsize` out 3, `axi_awburst` out 2, `axi_awready` in 1: write address channel.
- `axi_wvalid` out 1, `axi_wdata` out 256, `axi_wstrb` out 32, `axi_wlast` out 1, `axi_wready` in 1: write data channel.
- `axi_bvalid` in 1, `axi_bresp` in 2, `axi_bready` out 1: write response channel.

## Operation
- **Request latch:** `msg_start` while idle latches all `msg_*` inputs.
- **Illegal request:** `msg_length`=0 or `msg_tag`=15 pulses `msg_error` and issues no AXI traffic.
- **Fragmentation:**
  - If `msg_length` ≤ `MAX_PAYLOAD_BEATS`, send one SG fragment (type 2'b11, SN 0).
  - Otherwise send S (2'b10, SN 0), zero or more M (2'b00), then L (2'b01).
  - Each fragment carries min(remaining, `MAX_PAYLOAD_BEATS`) payload beats.
- **SN:** 2-bit, increments per fragment and wraps 3→0.
- **Header beat:**
  - `axi_wdata[127:0]` = {type, SN, tag, tlp}.
  - `axi_wdata[255:128]` = 0.
- **Payload beats:** read from `msg_sram_addr` plus the running beat offset, incrementing across fragments. The 10-bit address wraps modulo 1024.
- **Per fragment:**
  - `axi_awlen` = payload beat count; total beats = awlen+1.
  - `axi_awsize` = 3'b101, `axi_awburst` = 2'b01, `axi_wstrb` = all ones. These are constant.
- **FSM states:** IDLE → AW → W_HDR → {RD → RD_WAIT → W_DATA}×payload → B → (next fragment: AW | DONE) → IDLE.
  - RD: assert `sram_ren` for one cycle.
  - RD_WAIT: capture `sram_rdata` into `axi_wdata` and raise `axi_wvalid`.
- **B state:**
  - OKAY (2'b00): advance to the next fragment. After L/SG, go to DONE and pulse `msg_done`.
  - Any other response (SLVERR/DECERR): handled per Configuration.

## Timing
- **Registered outputs:** all outputs are registered.
- **Reset values:** every valid, ready, pulse, `sram_ren` and `msg_busy` output is 0. Address, len and data outputs are 0. `axi_awsize` is 3'b101, `axi_awburst` is 2'b01, `axi_wstrb` is all ones.
- **Accept latency:** `msg_busy` rises on the edge after `msg_start` is sampled; `axi_awvalid` rises one cycle later.
- **AW channel:** `axi_awvalid` and the AW fields are held stable until `axi_awready`. No W beat is issued before the AW handshake.
- **W channel:**
  - `axi_wvalid` and `axi_wdata` are held stable until `axi_wready`.
  - `axi_wlast` is high only on beat awlen.
  - A beat completes when `axi_wvalid` and `axi_wready` are both high on a rising edge.
- **B channel:** `axi_bready` is high only in state B. The response is consumed when `axi_bvalid` and `axi_bready` are both high.
- **Throughput:** a minimum of 3 cycles per payload beat is acceptable.
- **Ignored start:** `msg_start` while busy is ignored with no side effect.
- **Reset mid-message:** returns to IDLE immediately, drops all valids, and generates no `msg_done` or `msg_error`.
- **Exclusive pulses:** `msg_done` and `msg_error` never pulse together.

## Configuration
- Macro: `PCIE_MSG_TX_BRESP_RETRY_EN`.
- **Defined:**
  - A non-OKAY `axi_bresp` re-sends the same fragment once, with the same SN, header and SRAM range.
  - A second non-OKAY response on that fragment aborts the message: pulse `msg_error`, return to IDLE.
- **Undefined:** the first non-OKAY response aborts immediately. No further AW is issued.

## Test plan
1. **SG message:** length=4, tag=3, `MAX_PAYLOAD_BEATS`=15.
   - One AW with awlen=4.
   - Header [127:120]=8'hC3.
   - Beats 1..4 = SRAM[base..base+3], `axi_wlast` on beat 4.
   - `msg_done` pulses once.
2. **Three-fragment message:** length=40.
   - Fragments: S (SN0, awlen 15), M (SN1, awlen 15), L (SN2, awlen 10).
   - SRAM reads are contiguous base..base+39.
   - `axi_awaddr` is identical on all three fragments.
3. **SN wrap:** length=90.
   - Six fragments with types S,M,M,M,M,L and SNs 0,1,2,3,0,1.
   - Boundary check: length=15 gives SG; length=16 gives S(15)+L(1).
4. **Backpressure:** random low stretches on `axi_awready`, `axi_wready` and `axi_bvalid`.
   - Outputs stay stable while stalled.
   - No beats are dropped or duplicated.
   - A `msg_start` issued while busy is ignored.
5. **Error response:** `axi_bresp`=2'b10 on fragment 2 of the length-40 message.
   - Without the macro: `msg_error`, with no third AW.
   - With the macro: fragment 2 is re-sent with SN1; if it then returns OKAY, the message completes with `msg_done`.
6. **Illegal request and reset:**
   - length=0 gives `msg_error` with no AW; tag=15 gives `msg_error` with no AW.
   - `rst_n` low during W_DATA: all outputs return to reset values asynchronously, and the next request proceeds normally.
